// File: rtl/eff_sel_ctrl.sv
// Click-free effect selection sequencer: debounces the switch bank, fades the
// effects pipe to silence, swaps the selection, flushes stale samples, fades back in.
module eff_sel_ctrl #(
    parameter int DATA_W        = 24,
    parameter int SEL_W         = 16,
    parameter int DB_CYCLES     = 245760,
    parameter int RAMP_LOG2     = 6,
    parameter int FLUSH_SAMPLES = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_W-1:0]         sw_i,
    output logic [SEL_W-1:0]         sel_o,
    output logic                     en_o,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic                     vld_i,
    output logic signed [DATA_W-1:0] data_o,
    output logic                     vld_o,
    output logic [RAMP_LOG2:0]       gain_o,
    output logic                     busy_o
);

    localparam int G_W  = RAMP_LOG2 + 1;
    localparam int P_W  = DATA_W + G_W;
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int FL_W = (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES + 1) : 1;

    localparam logic [G_W-1:0]  GAIN_FULL = G_W'(2 ** RAMP_LOG2);
    localparam logic [G_W-1:0]  GAIN_ONE  = G_W'(1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [FL_W-1:0] FL_LAST   = FL_W'(FLUSH_SAMPLES - 1);

    typedef enum logic [2:0] {
        S_RUN,
        S_FADE_OUT,
        S_SWAP,
        S_FLUSH,
        S_FADE_IN
    } state_t;

    // Gain is zero-extended so the product stays signed; the arithmetic shift
    // floors toward -inf, and full gain reproduces the input exactly.
    function automatic logic signed [DATA_W-1:0] scale_sample(
        input logic signed [DATA_W-1:0] d,
        input logic [G_W-1:0]           g
    );
        logic signed [P_W-1:0] prod;
        prod = $signed({{G_W{d[DATA_W-1]}}, d}) * $signed({{DATA_W{1'b0}}, g});
        return DATA_W'(prod >>> RAMP_LOG2);
    endfunction

    logic [SEL_W-1:0]         sync1_q,  sync1_d;
    logic [SEL_W-1:0]         sw_s_q,   sw_s_d;
    logic [SEL_W-1:0]         cand_q,   cand_d;
    logic [DB_W-1:0]          db_cnt_q, db_cnt_d;
    logic [SEL_W-1:0]         stable_q, stable_d;
    state_t                   state_q,  state_d;
    logic [SEL_W-1:0]         sel_q,    sel_d;
    logic                     en_q,     en_d;
    logic [G_W-1:0]           gain_q,   gain_d;
    logic [FL_W-1:0]          fl_cnt_q, fl_cnt_d;
    logic signed [DATA_W-1:0] data_q,   data_d;
    logic                     vld_q,    vld_d;
    logic                     busy_q,   busy_d;
    logic                     pending;

    assign pending = (stable_q != sel_q);

    always_comb begin
        sync1_d  = sw_i;
        sw_s_d   = sync1_q;
        cand_d   = cand_q;
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        // Any movement restarts the stability window; the counter parks at its
        // last value once the candidate is accepted.
        if (sw_s_q != cand_q) begin
            cand_d   = sw_s_q;
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            stable_d = cand_q;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_comb begin
        vld_d  = vld_i;
        data_d = vld_i ? scale_sample(data_i, gain_q) : data_q;
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        gain_d   = gain_q;
        fl_cnt_d = fl_cnt_q;
        case (state_q)
            S_RUN: begin
                if (pending) state_d = S_FADE_OUT;
            end
            S_FADE_OUT: begin
                // Entered from FADE_IN at gain 0 there is nothing left to fade.
                if (gain_q == '0) begin
                    state_d = S_SWAP;
                end else if (vld_i) begin
                    gain_d = gain_q - GAIN_ONE;
                    if (gain_q == GAIN_ONE) state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                sel_d    = stable_q;
                fl_cnt_d = '0;
                state_d  = S_FLUSH;
            end
            S_FLUSH: begin
                if (pending) begin
                    state_d = S_SWAP;
                end else if (vld_i) begin
                    fl_cnt_d = fl_cnt_q + FL_W'(1);
                    if (fl_cnt_q == FL_LAST) state_d = S_FADE_IN;
                end
            end
            S_FADE_IN: begin
                // A new request reverses the ramp from where it stands.
                if (pending) begin
                    state_d = S_FADE_OUT;
                end else if (vld_i) begin
                    gain_d = gain_q + GAIN_ONE;
                    if (gain_q == GAIN_FULL - GAIN_ONE) state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
                gain_d  = GAIN_FULL;
            end
        endcase
        en_d   = (state_d != S_SWAP);
        busy_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sw_s_q   <= '0;
            cand_q   <= '0;
            db_cnt_q <= '0;
            stable_q <= '0;
            state_q  <= S_RUN;
            sel_q    <= '0;
            en_q     <= 1'b1;
            gain_q   <= GAIN_FULL;
            fl_cnt_q <= '0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sw_s_q   <= sw_s_d;
            cand_q   <= cand_d;
            db_cnt_q <= db_cnt_d;
            stable_q <= stable_d;
            state_q  <= state_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            gain_q   <= gain_d;
            fl_cnt_q <= fl_cnt_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
        end
    end

    assign sel_o  = sel_q;
    assign en_o   = en_q;
    assign gain_o = gain_q;
    assign data_o = data_q;
    assign vld_o  = vld_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_eff_sel_ctrl.sv
// Directed bench for eff_sel_ctrl: sample vectors with hand-computed gains and
// outputs, plus short sequences for glitch rejection, ramp reversal and reset.
module tb_eff_sel_ctrl;

    localparam int DATA_W = 24;
    localparam int SEL_W  = 16;
    localparam int RL2    = 2;

    logic                     clk;
    logic                     rst;
    logic [SEL_W-1:0]         sw_i;
    logic [SEL_W-1:0]         sel_o;
    logic                     en_o;
    logic signed [DATA_W-1:0] data_i;
    logic                     vld_i;
    logic signed [DATA_W-1:0] data_o;
    logic                     vld_o;
    logic [RL2:0]             gain_o;
    logic                     busy_o;

    int total = 0;
    int bad   = 0;
    int busy_hi = 0;
    int en_lo   = 0;
    bit mon_on  = 0;

    typedef struct {
        logic [SEL_W-1:0]         sw;
        logic signed [DATA_W-1:0] din;
        logic signed [DATA_W-1:0] dout;
        logic [RL2:0]             gain;
        logic                     busy;
    } vec_t;

    vec_t t1[2];
    vec_t t3[13];
    vec_t t5[20];
    vec_t t6[3];

    eff_sel_ctrl #(
        .DATA_W(DATA_W), .SEL_W(SEL_W), .DB_CYCLES(4),
        .RAMP_LOG2(RL2), .FLUSH_SAMPLES(3)
    ) dut (
        .clk(clk), .rst(rst), .sw_i(sw_i), .sel_o(sel_o), .en_o(en_o),
        .data_i(data_i), .vld_i(vld_i), .data_o(data_o), .vld_o(vld_o),
        .gain_o(gain_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_on && busy_o) busy_hi++;
        if (mon_on && !en_o) en_lo++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [SEL_W-1:0] sw, input int din,
                                input int dout, input int gain, input bit busy);
        vec_t v;
        v.sw   = sw;
        v.din  = DATA_W'(din);
        v.dout = DATA_W'(dout);
        v.gain = (RL2+1)'(gain);
        v.busy = busy;
        return v;
    endfunction

    // Called at a negedge; leaves at the negedge 8 clocks later.
    task automatic run_vec(input vec_t v, input string nm);
        chk({nm, " gain"}, longint'(gain_o), longint'(v.gain));
        chk({nm, " busy"}, longint'(busy_o), longint'(v.busy));
        sw_i   = v.sw;
        data_i = v.din;
        vld_i  = 1'b1;
        @(posedge clk); #1;
        chk({nm, " vld"}, longint'(vld_o), 1);
        chk({nm, " data"}, longint'(data_o), longint'(v.dout));
        @(negedge clk);
        vld_i = 1'b0;
        @(posedge clk); #1;
        chk({nm, " vld_drop"}, longint'(vld_o), 0);
        repeat (7) @(negedge clk);
    endtask

    initial begin
        t1[0] = mk(16'h0, 1000, 1000, 4, 0);
        t1[1] = mk(16'h0, -1, -1, 4, 0);

        t3[0]  = mk(16'h3, 100, 100, 4, 0);
        t3[1]  = mk(16'h3, 100, 100, 4, 1);
        t3[2]  = mk(16'h3, 100, 75, 3, 1);
        t3[3]  = mk(16'h3, 100, 50, 2, 1);
        t3[4]  = mk(16'h3, 100, 25, 1, 1);
        t3[5]  = mk(16'h3, 100, 0, 0, 1);
        t3[6]  = mk(16'h3, 100, 0, 0, 1);
        t3[7]  = mk(16'h3, 100, 0, 0, 1);
        t3[8]  = mk(16'h3, 100, 0, 0, 1);
        t3[9]  = mk(16'h3, 100, 25, 1, 1);
        t3[10] = mk(16'h3, 100, 50, 2, 1);
        t3[11] = mk(16'h3, 100, 75, 3, 1);
        t3[12] = mk(16'h3, 100, 100, 4, 0);

        t5[0]  = mk(16'h5, 100, 100, 4, 0);
        t5[1]  = mk(16'h5, 100, 100, 4, 1);
        t5[2]  = mk(16'h5, 100, 75, 3, 1);
        t5[3]  = mk(16'h5, 100, 50, 2, 1);
        t5[4]  = mk(16'h5, -3, -1, 1, 1);
        t5[5]  = mk(16'h5, 100, 0, 0, 1);
        t5[6]  = mk(16'h5, 100, 0, 0, 1);
        t5[7]  = mk(16'h5, 100, 0, 0, 1);
        t5[8]  = mk(16'h5, 100, 0, 0, 1);
        t5[9]  = mk(16'h7, 3, 0, 1, 1);
        t5[10] = mk(16'h7, 100, 50, 2, 1);
        t5[11] = mk(16'h7, 100, 25, 1, 1);
        t5[12] = mk(16'h7, 100, 0, 0, 1);
        t5[13] = mk(16'h7, 100, 0, 0, 1);
        t5[14] = mk(16'h7, 100, 0, 0, 1);
        t5[15] = mk(16'h7, 100, 0, 0, 1);
        t5[16] = mk(16'h7, 100, 25, 1, 1);
        t5[17] = mk(16'h7, 100, 50, 2, 1);
        t5[18] = mk(16'h7, 100, 75, 3, 1);
        t5[19] = mk(16'h7, 100, 100, 4, 0);

        t6[0] = mk(16'h3, 100, 100, 4, 0);
        t6[1] = mk(16'h3, 100, 100, 4, 1);
        t6[2] = mk(16'h3, 100, 75, 3, 1);

        rst = 1'b1; sw_i = '0; data_i = '0; vld_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst sel", longint'(sel_o), 0);
        chk("rst en", longint'(en_o), 1);
        chk("rst gain", longint'(gain_o), 4);
        chk("rst busy", longint'(busy_o), 0);
        chk("rst vld", longint'(vld_o), 0);
        chk("rst data", longint'(data_o), 0);
        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);

        // Plain pass-through at full gain.
        for (int i = 0; i < 2; i++) run_vec(t1[i], $sformatf("t1_%0d", i));
        chk("t1 sel", longint'(sel_o), 0);

        // A 2-clock glitch must not survive the debounce.
        busy_hi = 0;
        sw_i = 16'h1;
        repeat (2) @(negedge clk);
        sw_i = 16'h0;
        repeat (20) @(negedge clk);
        chk("t2 busy_cycles", busy_hi, 0);
        chk("t2 sel", longint'(sel_o), 0);

        // Full fade-out / swap / flush / fade-in.
        en_lo = 0;
        for (int i = 0; i < 13; i++) run_vec(t3[i], $sformatf("t3_%0d", i));
        chk("t3 sel", longint'(sel_o), 3);
        chk("t3 en_low_cycles", en_lo, 1);

        // Floor rounding at gain 1, then a request arriving mid fade-in.
        en_lo = 0;
        for (int i = 0; i < 20; i++) run_vec(t5[i], $sformatf("t5_%0d", i));
        chk("t5 sel", longint'(sel_o), 7);
        chk("t5 en_low_cycles", en_lo, 2);

        // Reset in the middle of a fade.
        for (int i = 0; i < 3; i++) run_vec(t6[i], $sformatf("t6_%0d", i));
        chk("t6 gain_pre_rst", longint'(gain_o), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6 rst gain", longint'(gain_o), 4);
        chk("t6 rst sel", longint'(sel_o), 0);
        chk("t6 rst busy", longint'(busy_o), 0);
        chk("t6 rst vld", longint'(vld_o), 0);
        chk("t6 rst en", longint'(en_o), 1);
        chk("t6 rst data", longint'(data_o), 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!busy_o && n < 40);
            chk("t6 refade_latency", n, 8);
        end
        run_vec(mk(16'h3, 100, 100, 4, 1), "t6_refade");
        chk("t6 gain_after", longint'(gain_o), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
